// File: rtl/if_inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   IB_TO_SP_BUS_W         width of the {rk, rj, rd, inst} bus to pre-decode
//   RD_LSB, RJ_LSB, RK_LSB register field offsets inside an instruction word
//   ib_entry_t             one queued fetch entry {excp, pc, inst}
//   pack_sp_bus()          builds the decoder bus from an instruction word
package if_inst_buffer_pkg;

  localparam int IB_TO_SP_BUS_W = 47;
  localparam int REG_W          = 5;
  localparam int RD_LSB         = 0;
  localparam int RJ_LSB         = 5;
  localparam int RK_LSB         = 10;

  typedef struct packed {
    logic        excp;
    logic [31:0] pc;
    logic [31:0] inst;
  } ib_entry_t;

  typedef logic [IB_TO_SP_BUS_W-1:0] ib_to_sp_bus_t;

  // Same layout as the decoder's input bus: {rk, rj, rd, inst}.
  function automatic ib_to_sp_bus_t pack_sp_bus(input logic [31:0] inst);
    return {inst[RK_LSB +: REG_W], inst[RJ_LSB +: REG_W], inst[RD_LSB +: REG_W], inst};
  endfunction

endpackage

// File: rtl/if_inst_buffer_ib_entry_ram.sv
// Entry storage for the instruction buffer: DEPTH x {excp, pc, inst}.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the caller only writes when a slot is free.
//
// Ports:
//   clk          clock
//   we           write enable
//   waddr/wdata  synchronous write port
//   raddr/rdata  asynchronous read port
// Data bits carry no reset; consumers mask the output with their own valid.
module ib_entry_ram
  import if_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ib_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output ib_entry_t     rdata
);

  ib_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_inst_buffer.sv
// Instruction buffer queuing fetch entries and presenting the head as {rk, rj, rd, inst}.
// Latency: 1 cycle empty-to-output; 0 cycles with IF_INST_BUFFER_BYPASS_EN defined.
// Backpressure: ib_allowin_o drops while full, from the registered count only (no path from id_allowin_i).
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   flush_i                             empty the buffer (wins over push/pop)
//   if_valid_i/if_pc_i/if_inst_i/if_excp_i, ib_allowin_o   fetch side
//   ib_valid_o/ib_pc_o/ib_excp_o/sp_to_obus, id_allowin_i  decode side
// Optional feature macro: IF_INST_BUFFER_BYPASS_EN (same-cycle forwarding when empty).
module if_inst_buffer
  import if_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      if_valid_i,
  input  logic [31:0]               if_pc_i,
  input  logic [31:0]               if_inst_i,
  input  logic                      if_excp_i,
  output logic                      ib_allowin_o,
  input  logic                      id_allowin_i,
  output logic                      ib_valid_o,
  output logic [31:0]               ib_pc_o,
  output logic                      ib_excp_o,
  output logic [IB_TO_SP_BUS_W-1:0] sp_to_obus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  ib_entry_t     fetch_ent;
  ib_entry_t     ram_rdata;
  ib_entry_t     head_ent;
  logic          stored_vld;
  logic          bypass;
  logic          push;
  logic          pop;

  assign fetch_ent  = '{excp: if_excp_i, pc: if_pc_i, inst: if_inst_i};
  assign stored_vld = (count != '0);

`ifdef IF_INST_BUFFER_BYPASS_EN
  // Empty buffer and a ready decoder: hand the fetch entry straight through
  // and skip storage entirely.
  assign bypass = (count == '0) && if_valid_i && id_allowin_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign ib_allowin_o = (count != FULL_CNT);
  // A bypassed entry is consumed in-cycle, so it is neither pushed nor popped.
  assign push = if_valid_i && ib_allowin_o && !bypass;
  assign pop  = stored_vld && id_allowin_i;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  ib_entry_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_entry_ram (
    .clk   (clk),
    .we    (push && rst_n && !flush_i),
    .waddr (wr_ptr),
    .wdata (fetch_ent),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign head_ent   = bypass ? fetch_ent : ram_rdata;
  assign ib_valid_o = stored_vld || bypass;

  // Zero the data outputs when nothing is valid so the decoder sees inst 0.
  assign ib_pc_o    = ib_valid_o ? head_ent.pc   : '0;
  assign ib_excp_o  = ib_valid_o ? head_ent.excp : 1'b0;
  assign sp_to_obus = ib_valid_o ? pack_sp_bus(head_ent.inst) : '0;

endmodule
